// File: rtl/soc_boot_loader_pkg.sv
// rtl/soc_boot_loader_pkg.sv - shared encodings for the serial boot loader
// Frame on the wire: BOOT_SYNC, addr_lo, addr_hi, len_lo, len_hi, data[len], chk.
package soc_boot_loader_pkg;

  localparam logic [7:0] BOOT_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_ADDR_LO   = 3'd1,
    ST_ADDR_HI   = 3'd2,
    ST_LEN_LO    = 3'd3,
    ST_LEN_HI    = 3'd4,
    ST_DATA      = 3'd5,
    ST_CHECK     = 3'd6,
    ST_RUN       = 3'd7
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/soc_boot_loader_if.sv
// rtl/soc_boot_loader_if.sv - RAM write port driven by the boot loader
interface soc_boot_loader_if;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;

  modport master (output mem_addr, output mem_wdata, output mem_we);
  modport slave  (input  mem_addr, input  mem_wdata, input  mem_we);

endinterface

// File: rtl/soc_boot_loader_acia_rx.sv
// rtl/soc_boot_loader_acia_rx.sv - 8N1 serial receiver timed by a clock-enable pulse
// clk_freq here is the rate of the pclk enable, not of clk.
module acia_rx
  import soc_boot_loader_pkg::*;
#(
  parameter int clk_freq = 4000000,
  parameter int sym_rate = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pclk,
  input  logic       rx,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_err
);

  localparam int DIV  = (clk_freq + sym_rate / 2) / sym_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dat_q, dat_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;
  logic        rx_s, rx_p;

  assign rx_s = sync_q[1];
  assign rx_p = sync_q[2];

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[1:0], rx};
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dat_d   = dat_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      // Only a falling edge starts a byte, so a line stuck low after a framing error stays idle.
      RX_IDLE: begin
        if (rx_p && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (pclk) begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (pclk) begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (pclk) begin
          if (cnt_q == CW'(DIV - 1)) begin
            state_d = RX_IDLE;
            if (rx_s) begin
              stb_d = 1'b1;
              dat_d = shift_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign rx_dat = dat_q;
  assign rx_stb = stb_q;
  assign rx_err = err_q;

endmodule

// File: rtl/soc_boot_loader.sv
// rtl/soc_boot_loader.sv - loads a framed serial image into RAM, then releases the CPU
// Falls through to ROM boot if no sync byte arrives before the timeout.
module soc_boot_loader
  import soc_boot_loader_pkg::*;
#(
  parameter int clk_freq      = 16000000,
  parameter int periph_freq   = 4000000,
  parameter int baudrate      = 115200,
  parameter int timeout_ticks = 4000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pclk,
  input  logic               rx,
  output logic               cpu_reset_n,
  soc_boot_loader_if.master  mem,
  output logic               busy,
  output logic               err,
  output logic               done
);

  localparam int TW = $clog2(timeout_ticks + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_ticks - 1);

  if (periph_freq > clk_freq || 2 * baudrate > periph_freq) begin : g_bad_cfg
    $error("soc_boot_loader: invalid clock/baud configuration");
  end

  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_err;

  acia_rx #(
    .clk_freq (periph_freq),
    .sym_rate (baudrate)
  ) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .pclk    (pclk),
    .rx      (rx),
    .rx_dat  (rx_dat),
    .rx_stb  (rx_stb),
    .rx_err  (rx_err)
  );

  boot_state_e   state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    xor_q, xor_d;
  logic          synced_q, synced_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cpu_q, cpu_d;
  logic [15:0]   maddr_q, maddr_d;
  logic [7:0]    mwdata_q, mwdata_d;
  logic          mwe_q, mwe_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          sync_byte;
  logic          tmo_expire;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    xor_d      = xor_q;
    synced_d   = synced_q;
    tmo_d      = tmo_q;
    cpu_d      = cpu_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    mwe_d      = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = done_q;
    tmo_expire = 1'b0;
    sync_byte  = rx_stb && !rx_err && (rx_dat == BOOT_SYNC);

    if (state_q == ST_WAIT_SYNC && !synced_q && pclk) begin
      tmo_d      = tmo_q + 1'b1;
      tmo_expire = (tmo_q == TMO_LAST);
    end

    case (state_q)
      ST_RUN: ;
      // A sync byte beats a simultaneous timeout; anything else lets the timeout win.
      ST_WAIT_SYNC: begin
        if (sync_byte) begin
          state_d  = ST_ADDR_LO;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          xor_d    = '0;
          synced_d = 1'b1;
        end else if (tmo_expire) begin
          state_d = ST_RUN;
          cpu_d   = 1'b1;
        end else if (rx_err) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        if (rx_err) begin
          state_d = ST_WAIT_SYNC;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (rx_stb) begin
          case (state_q)
            ST_ADDR_LO: begin
              addr_d[7:0] = rx_dat;
              state_d     = ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
              addr_d[15:8] = rx_dat;
              state_d      = ST_LEN_LO;
            end
            ST_LEN_LO: begin
              len_d[7:0] = rx_dat;
              state_d    = ST_LEN_HI;
            end
            ST_LEN_HI: begin
              len_d[15:8] = rx_dat;
              state_d     = ({rx_dat, len_q[7:0]} == 16'd0) ? ST_CHECK : ST_DATA;
            end
            ST_DATA: begin
              maddr_d  = addr_q;
              mwdata_d = rx_dat;
              mwe_d    = 1'b1;
              xor_d    = xor_q ^ rx_dat;
              addr_d   = addr_q + 16'd1;
              len_d    = len_q - 16'd1;
              if (len_q == 16'd1) state_d = ST_CHECK;
            end
            ST_CHECK: begin
              busy_d = 1'b0;
              if (rx_dat == xor_q) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
                cpu_d   = 1'b1;
              end else begin
                state_d = ST_WAIT_SYNC;
                err_d   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT_SYNC;
      addr_q   <= '0;
      len_q    <= '0;
      xor_q    <= '0;
      synced_q <= 1'b0;
      tmo_q    <= '0;
      cpu_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      xor_q    <= xor_d;
      synced_q <= synced_d;
      tmo_q    <= tmo_d;
      cpu_q    <= cpu_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign cpu_reset_n   = cpu_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;
  assign mem.mem_we    = mwe_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign done          = done_q;

endmodule
